// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage
//
// Generates the next PC, drives the instruction SRAM and hands {ce, pc} plus the
// matching instruction to ID. Branches that arrive while the PC is stalled are
// parked in a one-entry pending slot and consumed on the first unstalled cycle.
// A small hold FSM keeps the instruction returned by the synchronous SRAM stable
// while IF/ID is frozen.
//
// Handshake: there is no valid/ready pair. Progress is governed by the stall
// vector (1 = stop). stall[0] freezes the PC, stall[1] freezes IF/ID, and
// stall[1]&stall[2] means the whole front end is frozen, so the instruction is
// captured locally. stall[1] with stall[2]=0 is a bubble, which IF/ID flushes.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   stall[StallBus-1:0]   stall vector from the stall controller
//   br_bus[BR_WD-1:0]     {br_e, br_addr[31:0]} from ID
//   inst_sram_*           instruction SRAM (read data valid one cycle later)
//   if_to_id_bus          {ce_reg, pc_reg}
//   if_inst               instruction for pc_reg
//   fetch_adel            pc_reg misaligned while fetching
//   fetch_cnt             number of issued fetches (wraps)
//   dbg_state             hold FSM state (0 = FETCH, 1 = HOLD)
//   dbg_pend_valid        pending-branch flag
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter int StallBus    = 6,
    parameter int IF_TO_ID_WD = 33,
    parameter int BR_WD       = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [StallBus-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    input  logic [31:0]            inst_sram_rdata,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            if_inst,
    output logic                   fetch_adel,
    output logic [31:0]            fetch_cnt,
    output logic                   dbg_state,
    output logic                   dbg_pend_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } hold_state_e;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic [31:0] hold_inst;
    logic [31:0] next_pc;
    logic        ce_next;

    hold_state_e state, state_next;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // A fresh branch beats a parked one; a parked one beats sequential flow.
    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (stall[0]) begin
            next_pc = pc_reg;
        end else if (br_e) begin
            next_pc = br_addr;
        end else if (pend_valid) begin
            next_pc = pend_addr;
        end
    end

    // ce_next is the value ce_reg takes at the coming edge. Gating the SRAM
    // with it (rather than the registered ce_reg) lets the very first cycle
    // after reset release issue the fetch of 0xBFC0_0000, whose data then
    // lines up with pc_reg = 0xBFC0_0000 and ce_reg = 1.
    assign ce_next = ~rst & (ce_reg | ~stall[0]);

    assign inst_sram_en    = ce_next & ~stall[0] & (next_pc[1:0] == 2'b00);
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_addr  = next_pc;
    assign inst_sram_wdata = 32'b0;

    assign if_to_id_bus = {ce_reg, pc_reg};
    assign fetch_adel   = ce_reg & (pc_reg[1:0] != 2'b00);

    always_comb begin
        if_inst = inst_sram_rdata;
        if (fetch_adel) begin
            if_inst = 32'b0;
        end else if (state == HOLD) begin
            if_inst = hold_inst;
        end
    end

    // PC, chip enable, pending branch, fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            ce_reg     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= 32'b0;
            fetch_cnt  <= 32'b0;
        end else begin
            pc_reg <= next_pc;
            if (!stall[0]) begin
                ce_reg     <= 1'b1;
                pend_valid <= 1'b0;
            end else if (br_e) begin
                // Latest branch during a stall wins.
                pend_valid <= 1'b1;
                pend_addr  <= br_addr;
            end
            if (inst_sram_en) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // Hold FSM: state register and captured instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            hold_inst <= 32'b0;
        end else begin
            state <= state_next;
            if (state == FETCH && stall[1] && stall[2]) begin
                hold_inst <= inst_sram_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (stall[1] && stall[2]) state_next = HOLD;
            HOLD:  if (!stall[1])            state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    assign dbg_state      = (state == HOLD);
    assign dbg_pend_valid = pend_valid;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- directed bench for if_fetch with hand-computed expectations.
// Inputs change 1 ns after the rising edge; combinational outputs are checked
// 1 ns later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [32:0] if_to_id_bus;
    logic [31:0] if_inst;
    logic        fetch_adel;
    logic [31:0] fetch_cnt;
    logic        dbg_state;
    logic        dbg_pend_valid;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .inst_sram_rdata(inst_sram_rdata),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .if_to_id_bus   (if_to_id_bus),
        .if_inst        (if_inst),
        .fetch_adel     (fetch_adel),
        .fetch_cnt      (fetch_cnt),
        .dbg_state      (dbg_state),
        .dbg_pend_valid (dbg_pend_valid)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 6'b0;
        br_bus          = 33'b0;
        inst_sram_rdata = 32'h1111_1111;
        tick();
        tick();

        // reset state
        settle();
        check("rst_en",    inst_sram_en, 1'b0);
        check("rst_bus",   if_to_id_bus, 33'h0_BFBF_FFFC);
        check("rst_adel",  fetch_adel, 1'b0);
        check("rst_inst",  if_inst, 32'h1111_1111);
        check("rst_cnt",   fetch_cnt, 32'd0);
        check("rst_state", dbg_state, 1'b0);
        check("rst_wen",   inst_sram_wen, 4'b0);
        check("rst_wdata", inst_sram_wdata, 32'b0);

        // free run
        rst = 1'b0;
        settle();
        check("run_addr0", inst_sram_addr, 32'hBFC0_0000);
        check("run_en0",   inst_sram_en, 1'b1);
        tick();
        check("run_addr1", inst_sram_addr, 32'hBFC0_0004);
        check("run_bus1",  if_to_id_bus, 33'h1_BFC0_0000);
        check("run_cnt1",  fetch_cnt, 32'd1);
        tick();
        check("run_addr2", inst_sram_addr, 32'hBFC0_0008);
        tick();
        check("run_pc3",   if_to_id_bus, 33'h1_BFC0_0008);
        check("run_cnt3",  fetch_cnt, 32'd3);

        // branch
        br_bus = {1'b1, 32'hBFC0_0100};
        settle();
        check("br_addr", inst_sram_addr, 32'hBFC0_0100);
        tick();
        br_bus = 33'b0;
        settle();
        check("br_pc0", if_to_id_bus, 33'h1_BFC0_0100);
        tick();
        check("br_pc1", if_to_id_bus, 33'h1_BFC0_0104);
        check("br_cnt", fetch_cnt, 32'd5);

        // PC stall with two branches
        stall  = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0200};
        settle();
        check("st_en1",   inst_sram_en, 1'b0);
        check("st_addr1", inst_sram_addr, 32'hBFC0_0104);
        tick();
        br_bus = {1'b1, 32'hBFC0_0300};
        settle();
        check("st_pc2",   if_to_id_bus, 33'h1_BFC0_0104);
        check("st_pend2", dbg_pend_valid, 1'b1);
        tick();
        br_bus = 33'b0;
        settle();
        check("st_pc3",  if_to_id_bus, 33'h1_BFC0_0104);
        check("st_cnt3", fetch_cnt, 32'd5);
        tick();
        stall = 6'b0;
        settle();
        check("st_rel_addr", inst_sram_addr, 32'hBFC0_0300);
        check("st_rel_en",   inst_sram_en, 1'b1);
        tick();
        check("st_pc_after", if_to_id_bus, 33'h1_BFC0_0300);
        check("st_pend_clr", dbg_pend_valid, 1'b0);
        check("st_cnt",      fetch_cnt, 32'd6);

        // hold FSM
        inst_sram_rdata = 32'h3C08_BFC0;
        stall           = 6'b000111;
        settle();
        check("hd_entry_inst",  if_inst, 32'h3C08_BFC0);
        check("hd_entry_state", dbg_state, 1'b0);
        tick();
        inst_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hd_inst",  if_inst, 32'h3C08_BFC0);
            check("hd_state", dbg_state, 1'b1);
            tick();
        end
        stall = 6'b0;
        settle();
        check("hd_rel_inst",  if_inst, 32'h3C08_BFC0);
        check("hd_rel_state", dbg_state, 1'b1);
        tick();
        check("hd_after_inst",  if_inst, 32'hDEAD_BEEF);
        check("hd_after_state", dbg_state, 1'b0);
        check("hd_after_pc",    if_to_id_bus, 33'h1_BFC0_0304);
        check("hd_after_cnt",   fetch_cnt, 32'd7);

        // bubble: IF/ID stalled without stall[2] keeps the FSM in FETCH
        stall = 6'b000010;
        tick();
        check("bub_state", dbg_state, 1'b0);
        check("bub_inst",  if_inst, 32'hDEAD_BEEF);
        check("bub_bus",   if_to_id_bus, 33'h1_BFC0_0308);
        stall = 6'b0;

        // misaligned branch target, then recovery
        br_bus = {1'b1, 32'hBFC0_0102};
        settle();
        check("mis_en",   inst_sram_en, 1'b0);
        check("mis_addr", inst_sram_addr, 32'hBFC0_0102);
        tick();
        br_bus = 33'b0;
        settle();
        check("mis_adel", fetch_adel, 1'b1);
        check("mis_inst", if_inst, 32'b0);
        check("mis_en2",  inst_sram_en, 1'b0);
        br_bus = {1'b1, 32'hBFC0_0200};
        settle();
        check("rec_en", inst_sram_en, 1'b1);
        tick();
        br_bus = 33'b0;
        settle();
        check("rec_adel", fetch_adel, 1'b0);
        check("rec_bus",  if_to_id_bus, 33'h1_BFC0_0200);
        check("rec_inst", if_inst, 32'hDEAD_BEEF);

        // PC wrap
        br_bus = {1'b1, 32'hFFFF_FFFC};
        tick();
        br_bus = 33'b0;
        settle();
        check("wrap_addr", inst_sram_addr, 32'h0000_0000);
        check("wrap_en",   inst_sram_en, 1'b1);
        tick();

        // reset during HOLD with a pending branch
        stall  = 6'b000111;
        br_bus = {1'b1, 32'hBFC0_0500};
        tick();
        br_bus = 33'b0;
        settle();
        check("rh_state_pre", dbg_state, 1'b1);
        check("rh_pend_pre",  dbg_pend_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("rh_state", dbg_state, 1'b0);
        check("rh_pend",  dbg_pend_valid, 1'b0);
        check("rh_bus",   if_to_id_bus, 33'h0_BFBF_FFFC);
        check("rh_cnt",   fetch_cnt, 32'd0);
        check("rh_en",    inst_sram_en, 1'b0);
        rst   = 1'b0;
        stall = 6'b0;
        settle();
        check("rh_first_addr", inst_sram_addr, 32'hBFC0_0000);
        check("rh_first_en",   inst_sram_en, 1'b1);
        tick();
        check("rh_first_bus", if_to_id_bus, 33'h1_BFC0_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
